// File: rtl/dm_be.sv
// dm_be: byte-addressed data memory for the MIPS datapath.
//   Byte/half/word stores with lane merge and sign/zero-extended loads.
//   Registered read port (latency 1) behind a valid/ready request handshake.
//   A clear sequencer zeroes the whole array after reset.
//   Misaligned requests are detected and answered with err.
//
// Parameters
//   ADDR_W : word-index bits; DEPTH = 2**ADDR_W words of 32 bits
//   CLR_EN : 1 = zero the array after reset, 0 = go straight to READY
//
// Ports
//   clk       : system clock, posedge
//   reset_n   : synchronous active-low reset
//   req_valid : request present
//   req_ready : request can be accepted this cycle
//   we        : 1 store, 0 load
//   size      : 00 byte, 01 half, 10 word, 11 reserved (misaligned)
//   sign_ext  : loads only, 1 sign-extend / 0 zero-extend
//   addr      : byte address; word index = addr[ADDR_W+1:2]
//   wdata     : right-aligned store data
//   pc        : requesting PC, used only for the store trace
//   rdata     : extended load data, valid with rvalid
//   rvalid    : one-cycle response pulse for last cycle's accepted request
//   err       : with rvalid, request was misaligned and nothing was accessed
//
// Build option
//   DM_TRACE_EN : when defined, every committed store prints
//                 "@<pc>: *<word address> <= <merged word>".
module dm_be #(
  parameter int unsigned ADDR_W = 10,
  parameter bit          CLR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    CLEAR,
    READY
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic              rvalid_q, rvalid_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [31:0]       mem [DEPTH];

  logic [ADDR_W-1:0] word_idx;
  logic              misaligned;
  logic [31:0]       rd_word;
  logic [31:0]       rd_shift;
  logic [31:0]       load_data;
  logic [31:0]       wd_shift;
  logic [3:0]        byte_en;
  logic [31:0]       merged_word;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;

  // Upper address bits wrap and pc is only consumed by the optional trace.
  logic              unused_bits;
  assign unused_bits = ^{pc, addr[31:ADDR_W+2]};

  assign word_idx   = addr[ADDR_W+1:2];
  assign misaligned = (size == 2'b01 && addr[0]) ||
                      (size == 2'b10 && addr[1:0] != 2'b00) ||
                      (size == 2'b11);

  assign rd_word  = mem[word_idx];
  assign rd_shift = rd_word >> {addr[1:0], 3'b000};
  assign wd_shift = wdata << {addr[1:0], 3'b000};

  always_comb begin
    load_data = rd_word;
    unique case (size)
      2'b00:   load_data = sign_ext ? {{24{rd_shift[7]}}, rd_shift[7:0]}
                                    : {24'h0, rd_shift[7:0]};
      2'b01:   load_data = sign_ext ? {{16{rd_shift[15]}}, rd_shift[15:0]}
                                    : {16'h0, rd_shift[15:0]};
      default: load_data = rd_word;
    endcase
  end

  always_comb begin
    byte_en = 4'b1111;
    unique case (size)
      2'b00:   byte_en = 4'b0001 << addr[1:0];
      2'b01:   byte_en = addr[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  end

  always_comb begin
    merged_word = rd_word;
    for (int unsigned i = 0; i < 4; i++) begin
      if (byte_en[i]) merged_word[8*i +: 8] = wd_shift[8*i +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    rvalid_d  = 1'b0;
    err_d     = 1'b0;
    rdata_d   = '0;
    mem_we    = 1'b0;
    mem_waddr = word_idx;
    mem_wdata = merged_word;
    req_ready = 1'b0;

    unique case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_idx_q;
        mem_wdata = '0;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == '1) state_d = READY;
      end
      READY: begin
        req_ready = 1'b1;
        if (req_valid) begin
          rvalid_d = 1'b1;
          if (misaligned) begin
            err_d = 1'b1;
          end else if (we) begin
            mem_we = 1'b1;
          end else begin
            rdata_d = load_data;
          end
        end
      end
      default: state_d = READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= CLR_EN ? CLEAR : READY;
      clr_idx_q <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  // Array port is shared by the clear sequencer and stores; it is held off
  // during reset so a request sitting on the bus cannot commit.
  always_ff @(posedge clk) begin
    if (reset_n && mem_we) mem[mem_waddr] <= mem_wdata;
`ifdef DM_TRACE_EN
    if (reset_n && state_q == READY && req_valid && we && !misaligned)
      $display("@%h: *%h <= %h", pc, {addr[31:2], 2'b00}, merged_word);
`endif
  end

  assign rvalid = rvalid_q;
  assign err    = err_q;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_dm_be.sv
module tb_dm_be;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned NBYTES = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b10;
  logic        sign_ext = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] pc = '0;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err;

  int checks = 0;
  int errors = 0;

  // Reference model: flat little-endian byte memory.
  logic [7:0]  ref_mem [NBYTES];
  bit          exp_v;
  bit          exp_err;
  logic [31:0] exp_rdata;
  string       cur_test = "init";

  always #5 clk = ~clk;

  dm_be #(.ADDR_W(ADDR_W), .CLR_EN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .we(we), .size(size), .sign_ext(sign_ext), .addr(addr), .wdata(wdata),
    .pc(pc), .rdata(rdata), .rvalid(rvalid), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s/%s: observed %h expected %h", cur_test, tag, obs, expv);
    end
  endtask

  function automatic bit model_misaligned(input logic [1:0] sz, input logic [31:0] a);
    int unsigned nbytes;
    if (sz == 2'b11) return 1'b1;
    nbytes = 1 << sz;
    return (a % nbytes) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input bit sx,
                                             input logic [31:0] a);
    int unsigned b = a % NBYTES;
    int          s;
    logic [7:0]  v8;
    logic [15:0] v16;
    if (sz == 2'b00) begin
      v8 = ref_mem[b];
      if (sx) s = $signed(v8); else s = int'(v8);
      return s;
    end else if (sz == 2'b01) begin
      v16 = {ref_mem[b+1], ref_mem[b]};
      if (sx) s = $signed(v16); else s = int'(v16);
      return s;
    end
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int unsigned b = a % NBYTES;
    int unsigned n = 1 << sz;
    logic [31:0] dd = d;
    for (int unsigned i = 0; i < n; i++) begin
      ref_mem[b+i] = dd[7:0];
      dd = dd >> 8;
    end
  endtask

  // One cycle: check the response due now, then present the next request.
  task automatic step(input bit v, input bit w, input logic [1:0] sz, input bit sx,
                      input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    chk("rvalid", {31'b0, rvalid}, {31'b0, exp_v});
    chk("err",    {31'b0, err},    {31'b0, exp_err});
    chk("rdata",  rdata,           exp_rdata);
    if (v) chk("req_ready", {31'b0, req_ready}, 32'd1);
    req_valid = v; we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
    pc = $urandom;
    exp_v = v; exp_err = 1'b0; exp_rdata = '0;
    if (v) begin
      if (model_misaligned(sz, a)) exp_err = 1'b1;
      else if (w) model_store(sz, a, d);
      else exp_rdata = model_load(sz, sx, a);
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic wait_ready(input string tag);
    int cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (!req_ready) chk({tag, "_busy_rvalid"}, {31'b0, rvalid}, 32'd0);
    end while (!req_ready && cycles < 100);
    chk({tag, "_clear_cycles"}, cycles, DEPTH);
    for (int unsigned i = 0; i < NBYTES; i++) ref_mem[i] = 8'h00;
    exp_v = 1'b0; exp_err = 1'b0; exp_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready",  {31'b0, req_ready}, 32'd0);
    chk("rst_rvalid", {31'b0, rvalid},    32'd0);
    chk("rst_err",    {31'b0, err},       32'd0);
    chk("rst_rdata",  rdata,              32'd0);
    reset_n = 1'b1;
    wait_ready("reset");
  endtask

  initial begin
    // 1: clear sequencer zeroes previously written data
    cur_test = "t1";
    do_reset();
    step(1, 1, 2'b10, 0, 32'h0000_000C, 32'hFFFF_FFFF);
    step(1, 0, 2'b10, 0, 32'h0000_000C, 32'h0);
    idle();
    do_reset();
    step(1, 0, 2'b10, 0, 32'h0000_000C, 32'h0);
    idle();

    // 2: word store, byte merge, byte loads
    cur_test = "t2";
    step(1, 1, 2'b10, 0, 32'h0000_0010, 32'h1234_5678);
    step(1, 1, 2'b00, 0, 32'h0000_0011, 32'h0000_00AB);
    step(1, 0, 2'b10, 0, 32'h0000_0010, 32'h0);
    step(1, 0, 2'b00, 1, 32'h0000_0011, 32'h0);
    step(1, 0, 2'b00, 0, 32'h0000_0011, 32'h0);

    // 3: upper-half store and loads
    cur_test = "t3";
    step(1, 1, 2'b01, 0, 32'h0000_0022, 32'h0000_8001);
    step(1, 0, 2'b01, 1, 32'h0000_0022, 32'h0);
    step(1, 0, 2'b01, 0, 32'h0000_0022, 32'h0);
    step(1, 0, 2'b10, 0, 32'h0000_0020, 32'h0);

    // 4: misaligned requests, memory unchanged afterwards
    cur_test = "t4";
    step(1, 0, 2'b10, 0, 32'h0000_0013, 32'h0);
    step(1, 1, 2'b01, 0, 32'h0000_0015, 32'h5555_5555);
    step(1, 1, 2'b11, 0, 32'h0000_0010, 32'hAAAA_AAAA);
    step(1, 0, 2'b10, 0, 32'h0000_0010, 32'h0);
    step(1, 0, 2'b10, 0, 32'h0000_0014, 32'h0);

    // 5: back-to-back store then load of the same word
    cur_test = "t5";
    step(1, 1, 2'b10, 0, 32'h0000_0040 & 32'h3C, 32'hDEAD_BEEF);
    step(1, 0, 2'b10, 0, 32'h0000_0040 & 32'h3C, 32'h0);
    step(1, 1, 2'b10, 0, 32'h0000_0040, 32'hDEAD_BEEF);
    step(1, 0, 2'b10, 0, 32'h0000_0040, 32'h0);
    idle();
    idle();

    // random traffic, upper address bits random to exercise wrap
    cur_test = "rand";
    for (int n = 0; n < 300; n++) begin
      step(($urandom_range(0, 3) != 0), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
           $urandom_range(0, 1), $urandom, $urandom);
    end
    idle();
    idle();

    // 6: reset mid-clear restarts the sequencer
    cur_test = "t6";
    @(negedge clk);
    reset_n = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("midclr_ready", {31'b0, req_ready}, 32'd0);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    wait_ready("midclr");
    step(1, 0, 2'b10, 0, 32'h0000_0010, 32'h0);
    step(1, 0, 2'b10, 0, 32'h0000_003C, 32'h0);
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
